// File: rtl/axi_st_h2h_pkg.sv
// Shared definitions for the AXIST simplex test sequencer.
//   seq_state_e   : sequencer FSM state encoding (also exported on seq_state)
//   CHK_*         : checker_status verdict codes from the pattern checker
//   norm_pat_cnt  : maps the illegal pattern count 0 to 1
package axi_st_h2h_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_MASK    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_GAP     = 3'd4,
    ST_FINISH  = 3'd5,
    ST_CONT    = 3'd6,
    ST_GAP_END = 3'd7
  } seq_state_e;

  localparam logic [1:0] CHK_BUSY = 2'b00;
  localparam logic [1:0] CHK_PASS = 2'b11;
  localparam logic [1:0] CHK_FAIL = 2'b10;

  localparam int PAT_CNT_W = 9;

  // A zero-beat run is meaningless to the generator, so it becomes one beat.
  function automatic logic [PAT_CNT_W-1:0] norm_pat_cnt(input logic [PAT_CNT_W-1:0] cnt);
    return (cnt == '0) ? PAT_CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/axi_st_h2h_sat_cnt.sv
// Saturating up-counter used for the pass and fail statistics.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : add one unless already at all-ones
//   cnt_o      : registered count
module axi_st_h2h_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_st_h2h_test_seq.sv
// Run sequencer for the AXIST simplex pattern generator/checker pair.
// Programs the pattern count, fires the generator/checker start pulses,
// masks the checker's clear window, waits for a verdict or timeout and
// repeats for the programmed number of runs, keeping pass/fail statistics.
//
// Ports:
//   rdclk, rst_n     : receive-domain clock, asynchronous active-low reset
//   start            : one-cycle start request, accepted only when idle
//   abort            : level, returns the sequencer to idle (ends CONT mode)
//   cfg_pat_cnt      : beats per run (0 treated as 1)
//   cfg_num_runs     : runs per test (0 = until abort)
//   cfg_timeout      : per-run cycle limit (0 = disabled)
//   cfg_cntus        : continuous-pattern mode select
//   checker_status   : checker verdict (00 busy, 11 pass, 10 fail)
//   chkr_fifo_full   : checker reference FIFO full, holds off a launch
//   patgen_cnt       : pattern count to generator and checker
//   patgen_en        : one-cycle generator start pulse
//   patchkr_en       : one-cycle checker start pulse (same cycle as patgen_en)
//   cntuspatt_en     : continuous-pattern enable level
//   busy             : high whenever not idle
//   test_done        : one-cycle pulse on normal completion
//   pass_cnt         : saturating count of passed runs
//   fail_cnt         : saturating count of failed and timed-out runs
//   timeout_err      : sticky timeout flag, cleared on accepted start
//   seq_state        : current FSM state, for debug
//
// Handshake: start is a single-cycle request with no acknowledge; it is
// taken only in IDLE and silently dropped otherwise. patgen_en/patchkr_en
// are fire-and-forget pulses; checker_status is a level that is trusted
// only in WAIT and on the final GAP_END cycle.
module axi_st_h2h_test_seq
  import axi_st_h2h_pkg::*;
#(
  parameter int RUN_CNT_W = 8,
  parameter int TO_W      = 16,
  parameter int CLR_WAIT  = 4,
  parameter int GAP_CYC   = 8
) (
  input  logic                 rdclk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [8:0]           cfg_pat_cnt,
  input  logic [RUN_CNT_W-1:0] cfg_num_runs,
  input  logic [TO_W-1:0]      cfg_timeout,
  input  logic                 cfg_cntus,
  input  logic [1:0]           checker_status,
  input  logic                 chkr_fifo_full,
  output logic [8:0]           patgen_cnt,
  output logic                 patgen_en,
  output logic                 patchkr_en,
  output logic                 cntuspatt_en,
  output logic                 busy,
  output logic                 test_done,
  output logic [RUN_CNT_W-1:0] pass_cnt,
  output logic [RUN_CNT_W-1:0] fail_cnt,
  output logic                 timeout_err,
  output logic [2:0]           seq_state
);

  localparam int MW = (CLR_WAIT < 1) ? 1 : $clog2(CLR_WAIT + 1);
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  seq_state_e           state_q;
  logic [RUN_CNT_W-1:0] num_runs_q;
  logic [TO_W-1:0]      timeout_q;
  logic [8:0]           patgen_cnt_q;
  logic                 pulse_q;
  logic                 cntus_q;
  logic                 test_done_q;
  logic                 timeout_err_q;
  logic [MW-1:0]        mask_cnt_q;
  logic [TO_W-1:0]      to_cnt_q;
  logic [GW-1:0]        gap_cnt_q;
  logic [RUN_CNT_W-1:0] runs_done_q;

  logic                 start_acc;
  logic                 verdict_pass;
  logic                 verdict_fail;
  logic                 wait_live;
  logic                 gap_end_last;
  logic [TO_W-1:0]      to_inc;
  logic                 to_hit;
  logic                 gap_last;
  logic [RUN_CNT_W-1:0] runs_inc;
  logic                 run_last;
  logic                 pass_inc;
  logic                 fail_inc;

  assign start_acc    = (state_q == ST_IDLE) && start;
  assign verdict_pass = (checker_status == CHK_PASS);
  assign verdict_fail = (checker_status == CHK_FAIL);
  // Abort takes priority over a verdict arriving in the same WAIT cycle.
  assign wait_live    = (state_q == ST_WAIT) && !abort;

  // The timeout fires on the cycle the incremented count would equal the
  // limit, so a limit of N gives exactly N cycles in WAIT.
  assign to_inc   = to_cnt_q + TO_W'(1);
  assign to_hit   = (timeout_q != '0) && (to_inc == timeout_q);

  assign gap_last     = (gap_cnt_q == GW'(GAP_CYC - 1));
  assign gap_end_last = (state_q == ST_GAP_END) && gap_last;
  assign runs_inc     = runs_done_q + RUN_CNT_W'(1);
  assign run_last     = (num_runs_q != '0) && (runs_inc == num_runs_q);

  assign pass_inc = (wait_live && verdict_pass) || (gap_end_last && verdict_pass);
  assign fail_inc = (wait_live && (verdict_fail || (!verdict_pass && to_hit))) ||
                    (gap_end_last && verdict_fail);

  axi_st_h2h_sat_cnt #(.W(RUN_CNT_W)) u_pass_cnt (
    .clk   (rdclk),
    .rst_n (rst_n),
    .clr_i (start_acc),
    .inc_i (pass_inc),
    .cnt_o (pass_cnt)
  );

  axi_st_h2h_sat_cnt #(.W(RUN_CNT_W)) u_fail_cnt (
    .clk   (rdclk),
    .rst_n (rst_n),
    .clr_i (start_acc),
    .inc_i (fail_inc),
    .cnt_o (fail_cnt)
  );

  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      num_runs_q    <= '0;
      timeout_q     <= '0;
      patgen_cnt_q  <= '0;
      pulse_q       <= 1'b0;
      cntus_q       <= 1'b0;
      test_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      mask_cnt_q    <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      runs_done_q   <= '0;
    end else begin
      pulse_q     <= 1'b0;
      test_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_runs_q    <= cfg_num_runs;
            timeout_q     <= cfg_timeout;
            patgen_cnt_q  <= norm_pat_cnt(cfg_pat_cnt);
            timeout_err_q <= 1'b0;
            runs_done_q   <= '0;
            if (cfg_cntus) begin
              cntus_q <= 1'b1;
              state_q <= ST_CONT;
            end else begin
              state_q <= ST_LAUNCH;
            end
          end
        end

        ST_LAUNCH: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (!chkr_fifo_full) begin
            pulse_q    <= 1'b1;
            mask_cnt_q <= MW'(CLR_WAIT);
            state_q    <= ST_MASK;
          end
        end

        // MASK lasts CLR_WAIT cycles, starting with the pulse cycle.
        ST_MASK: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (mask_cnt_q <= MW'(1)) begin
            to_cnt_q <= '0;
            state_q  <= ST_WAIT;
          end else begin
            mask_cnt_q <= mask_cnt_q - MW'(1);
          end
        end

        ST_WAIT: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (verdict_pass || verdict_fail) begin
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end else if (to_hit) begin
            timeout_err_q <= 1'b1;
            gap_cnt_q     <= '0;
            state_q       <= ST_GAP;
          end else begin
            to_cnt_q <= to_inc;
          end
        end

        ST_GAP: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (gap_last) begin
            // runs_done wraps freely when the run count is unlimited.
            runs_done_q <= runs_inc;
            if (run_last) begin
              test_done_q <= 1'b1;
              state_q     <= ST_FINISH;
            end else begin
              state_q <= ST_LAUNCH;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end

        ST_FINISH: begin
          state_q <= ST_IDLE;
        end

        ST_CONT: begin
          if (abort) begin
            cntus_q   <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP_END;
          end
        end

        // Drain time before the single verdict sample in continuous mode.
        ST_GAP_END: begin
          if (gap_last) begin
            test_done_q <= 1'b1;
            state_q     <= ST_FINISH;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign patgen_cnt   = patgen_cnt_q;
  assign patgen_en    = pulse_q;
  assign patchkr_en   = pulse_q;
  assign cntuspatt_en = cntus_q;
  assign busy         = (state_q != ST_IDLE);
  assign test_done    = test_done_q;
  assign timeout_err  = timeout_err_q;
  assign seq_state    = state_q;

endmodule
